// File: rtl/sd_sec_sched.sv
// Multi-sector job scheduler: arbitrates a read and a write client and issues one
// single-sector start pulse per sector to the SD controller, tracking its busy handshake.
module sd_sec_sched #(
  parameter int SEC_CNT_W = 16,
  parameter int BUSY_TMO  = 255
) (
  input  logic                 clk_ref,
  input  logic                 rst_n,
  input  logic                 sd_init_done,
  input  logic                 rd_req,
  input  logic [31:0]          rd_base_addr,
  input  logic [SEC_CNT_W-1:0] rd_sec_num,
  output logic                 rd_ack,
  output logic                 rd_done,
  input  logic                 wr_req,
  input  logic [31:0]          wr_base_addr,
  input  logic [SEC_CNT_W-1:0] wr_sec_num,
  output logic                 wr_ack,
  output logic                 wr_done,
  output logic                 sd_rd_start_en,
  output logic [31:0]          sd_rd_sec_addr,
  input  logic                 sd_rd_busy,
  output logic                 sd_wr_start_en,
  output logic [31:0]          sd_wr_sec_addr,
  input  logic                 sd_wr_busy,
  output logic [SEC_CNT_W-1:0] sec_cnt,
  output logic                 timeout_err,
  output logic                 sched_busy
);

  localparam int TMO_W = (BUSY_TMO < 2) ? 1 : $clog2(BUSY_TMO + 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(BUSY_TMO);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_WAIT_HI, ST_WAIT_LO, ST_FIN
  } state_t;

  state_t               state_q;
  logic                 is_wr_q;
  logic                 last_wr_q;
  logic [31:0]          cur_addr_q;
  logic [SEC_CNT_W-1:0] num_q;
  logic [SEC_CNT_W-1:0] sec_cnt_q;
  logic [TMO_W-1:0]     tmo_cnt_q;
  logic                 rd_ack_q, wr_ack_q, rd_done_q, wr_done_q;
  logic                 rd_start_q, wr_start_q;
  logic [31:0]          rd_addr_q, wr_addr_q;
  logic                 err_q, busy_q;

  logic                 accept_d;
  logic                 sel_wr_d;
  logic [31:0]          base_d;
  logic [SEC_CNT_W-1:0] num_d;
  logic [SEC_CNT_W-1:0] sec_cnt_d;
  logic                 sel_busy_d;

  // Round-robin on a tie: serve the type opposite to the last job served.
  always_comb begin
    accept_d   = sd_init_done && (rd_req || wr_req);
    sel_wr_d   = wr_req && (!rd_req || !last_wr_q);
    base_d     = sel_wr_d ? wr_base_addr : rd_base_addr;
    num_d      = sel_wr_d ? wr_sec_num : rd_sec_num;
    sec_cnt_d  = sec_cnt_q + SEC_CNT_W'(1);
    sel_busy_d = is_wr_q ? sd_wr_busy : sd_rd_busy;
  end

  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      is_wr_q    <= 1'b0;
      last_wr_q  <= 1'b1;
      cur_addr_q <= '0;
      num_q      <= '0;
      sec_cnt_q  <= '0;
      tmo_cnt_q  <= '0;
      rd_ack_q   <= 1'b0;
      wr_ack_q   <= 1'b0;
      rd_done_q  <= 1'b0;
      wr_done_q  <= 1'b0;
      rd_start_q <= 1'b0;
      wr_start_q <= 1'b0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rd_ack_q   <= 1'b0;
      wr_ack_q   <= 1'b0;
      rd_done_q  <= 1'b0;
      wr_done_q  <= 1'b0;
      rd_start_q <= 1'b0;
      wr_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept_d) begin
            rd_ack_q   <= !sel_wr_d;
            wr_ack_q   <= sel_wr_d;
            is_wr_q    <= sel_wr_d;
            last_wr_q  <= sel_wr_d;
            cur_addr_q <= base_d;
            num_q      <= num_d;
            sec_cnt_q  <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= (num_d == '0) ? ST_FIN : ST_START;
          end
        end
        ST_START: begin
          if (!sd_init_done) begin
            err_q   <= 1'b1;
            state_q <= ST_FIN;
          end else begin
            if (is_wr_q) begin
              wr_start_q <= 1'b1;
              wr_addr_q  <= cur_addr_q;
            end else begin
              rd_start_q <= 1'b1;
              rd_addr_q  <= cur_addr_q;
            end
            tmo_cnt_q <= '0;
            state_q   <= ST_WAIT_HI;
          end
        end
        ST_WAIT_HI: begin
          if (!sd_init_done) begin
            err_q   <= 1'b1;
            state_q <= ST_FIN;
          end else if (sel_busy_d) begin
            state_q <= ST_WAIT_LO;
          end else if (tmo_cnt_q == TMO_MAX) begin
            err_q   <= 1'b1;
            state_q <= ST_FIN;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
          end
        end
        ST_WAIT_LO: begin
          if (!sd_init_done) begin
            err_q   <= 1'b1;
            state_q <= ST_FIN;
          end else if (!sel_busy_d) begin
            sec_cnt_q  <= sec_cnt_d;
            cur_addr_q <= cur_addr_q + 32'd1;
            state_q    <= (sec_cnt_d == num_q) ? ST_FIN : ST_START;
          end
        end
        ST_FIN: begin
          rd_done_q <= !is_wr_q;
          wr_done_q <= is_wr_q;
          busy_q    <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rd_ack         = rd_ack_q;
  assign wr_ack         = wr_ack_q;
  assign rd_done        = rd_done_q;
  assign wr_done        = wr_done_q;
  assign sd_rd_start_en = rd_start_q;
  assign sd_wr_start_en = wr_start_q;
  assign sd_rd_sec_addr = rd_addr_q;
  assign sd_wr_sec_addr = wr_addr_q;
  assign sec_cnt        = sec_cnt_q;
  assign timeout_err    = err_q;
  assign sched_busy     = busy_q;

endmodule

// File: tb/tb_sd_sec_sched.sv
// Directed bench for sd_sec_sched: a small busy model of the SD controller, a scoreboard
// of expected {is_wr, address} start pulses, and hand-computed cycle-level checks.
module tb_sd_sec_sched;

  logic        clk_ref = 1'b0;
  logic        rst_n;
  logic        sd_init_done;
  logic        rd_req, wr_req;
  logic [31:0] rd_base_addr, wr_base_addr;
  logic [15:0] rd_sec_num, wr_sec_num;
  logic        rd_ack, rd_done, wr_ack, wr_done;
  logic        sd_rd_start_en, sd_wr_start_en;
  logic [31:0] sd_rd_sec_addr, sd_wr_sec_addr;
  logic        sd_rd_busy, sd_wr_busy;
  logic [15:0] sec_cnt;
  logic        timeout_err, sched_busy;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [32:0] exp_q[$];
  logic        model_en = 1'b1;
  logic        mw;
  int          rd_ack_cnt = 0, wr_ack_cnt = 0, rd_done_cnt = 0, wr_done_cnt = 0;

  sd_sec_sched #(.SEC_CNT_W(16), .BUSY_TMO(10)) dut (
    .clk_ref(clk_ref), .rst_n(rst_n), .sd_init_done(sd_init_done),
    .rd_req(rd_req), .rd_base_addr(rd_base_addr), .rd_sec_num(rd_sec_num),
    .rd_ack(rd_ack), .rd_done(rd_done),
    .wr_req(wr_req), .wr_base_addr(wr_base_addr), .wr_sec_num(wr_sec_num),
    .wr_ack(wr_ack), .wr_done(wr_done),
    .sd_rd_start_en(sd_rd_start_en), .sd_rd_sec_addr(sd_rd_sec_addr), .sd_rd_busy(sd_rd_busy),
    .sd_wr_start_en(sd_wr_start_en), .sd_wr_sec_addr(sd_wr_sec_addr), .sd_wr_busy(sd_wr_busy),
    .sec_cnt(sec_cnt), .timeout_err(timeout_err), .sched_busy(sched_busy)
  );

  // clock / watchdog
  always #5 clk_ref = ~clk_ref;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // controller busy model: busy rises 2 cycles after a start pulse and lasts 20 cycles
  initial begin
    sd_rd_busy = 1'b0;
    sd_wr_busy = 1'b0;
    forever begin
      @(negedge clk_ref);
      if (model_en && (sd_rd_start_en || sd_wr_start_en)) begin
        mw = sd_wr_start_en;
        repeat (2) @(negedge clk_ref);
        if (mw) sd_wr_busy = 1'b1;
        else    sd_rd_busy = 1'b1;
        repeat (20) @(negedge clk_ref);
        sd_rd_busy = 1'b0;
        sd_wr_busy = 1'b0;
      end
    end
  end

  // scoreboard and pulse counters
  always @(negedge clk_ref) begin
    if (rd_ack)  rd_ack_cnt++;
    if (wr_ack)  wr_ack_cnt++;
    if (rd_done) rd_done_cnt++;
    if (wr_done) wr_done_cnt++;
    if (sd_rd_start_en || sd_wr_start_en) begin
      check("sb_nonempty", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0)
        check("sb_start", {sd_wr_start_en, sd_rd_start_en,
                           sd_wr_start_en ? sd_wr_sec_addr : sd_rd_sec_addr},
              {exp_q[0][32], ~exp_q[0][32], exp_q[0][31:0]});
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic start_job(input logic wr, input logic [31:0] base, input logic [15:0] num);
    if (wr) begin
      wr_req = 1'b1; wr_base_addr = base; wr_sec_num = num;
    end else begin
      rd_req = 1'b1; rd_base_addr = base; rd_sec_num = num;
    end
  endtask

  task automatic wait_ack(input logic wr, input string tag);
    int lat;
    lat = -1;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk_ref);
      if (wr ? wr_ack : rd_ack) begin
        lat = c;
        break;
      end
    end
    check(tag, lat, 1);
    if (wr) wr_req = 1'b0;
    else    rd_req = 1'b0;
  endtask

  task automatic wait_done(input logic wr, input string tag);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk_ref);
      if (wr ? wr_done : rd_done) begin
        seen = 1'b1;
        break;
      end
    end
    check(tag, seen, 1'b1);
  endtask

  task automatic wait_busy(input logic wr, input string tag);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_ref);
      if (wr ? sd_wr_busy : sd_rd_busy) begin
        seen = 1'b1;
        break;
      end
    end
    check(tag, seen, 1'b1);
  endtask

  task automatic pair(input logic [31:0] rb, input logic [31:0] wb, input logic exp_first_wr,
                      input string tag);
    int   n_ack;
    logic ord[2];
    n_ack  = 0;
    ord[0] = 1'b0;
    ord[1] = 1'b0;
    if (exp_first_wr) begin
      exp_q.push_back({1'b1, wb}); exp_q.push_back({1'b0, rb});
    end else begin
      exp_q.push_back({1'b0, rb}); exp_q.push_back({1'b1, wb});
    end
    start_job(1'b0, rb, 16'd1);
    start_job(1'b1, wb, 16'd1);
    for (int c = 0; c < 400 && n_ack < 2; c++) begin
      @(negedge clk_ref);
      if (rd_ack && n_ack < 2) begin ord[n_ack] = 1'b0; n_ack++; rd_req = 1'b0; end
      if (wr_ack && n_ack < 2) begin ord[n_ack] = 1'b1; n_ack++; wr_req = 1'b0; end
    end
    rd_req = 1'b0;
    wr_req = 1'b0;
    check({tag, "_acks"}, n_ack, 2);
    check({tag, "_first"}, ord[0], exp_first_wr);
    check({tag, "_second"}, ord[1], !exp_first_wr);
    wait_done(!exp_first_wr, {tag, "_done"});
    repeat (2) @(negedge clk_ref);
  endtask

  initial begin
    int d0;
    logic seen;
    rst_n = 1'b0; sd_init_done = 1'b0;
    rd_req = 1'b0; wr_req = 1'b0;
    rd_base_addr = '0; wr_base_addr = '0; rd_sec_num = '0; wr_sec_num = '0;
    repeat (3) @(negedge clk_ref);
    check("rst_flags", {rd_ack, rd_done, wr_ack, wr_done, sd_rd_start_en, sd_wr_start_en,
                        timeout_err, sched_busy}, 8'h00);
    check("rst_addr", {sd_rd_sec_addr, sd_wr_sec_addr}, 64'h0);
    check("rst_sec_cnt", sec_cnt, 16'h0);
    rst_n = 1'b1;
    sd_init_done = 1'b1;
    repeat (2) @(negedge clk_ref);

    // round robin: read wins first tie, alternation follows the last served type
    pair(32'h10, 32'h20, 1'b0, "rr1");
    pair(32'h11, 32'h21, 1'b0, "rr2");
    exp_q.push_back({1'b0, 32'h30});
    start_job(1'b0, 32'h30, 16'd1);
    wait_ack(1'b0, "lone_rd_ack");
    wait_done(1'b0, "lone_rd_done");
    repeat (2) @(negedge clk_ref);
    pair(32'h12, 32'h22, 1'b1, "rr3");

    // read 3 sectors from 0x100 with cycle-exact accept / first start
    exp_q.push_back({1'b0, 32'h100});
    exp_q.push_back({1'b0, 32'h101});
    exp_q.push_back({1'b0, 32'h102});
    d0 = rd_done_cnt;
    start_job(1'b0, 32'h100, 16'd3);
    @(negedge clk_ref);
    check("t1_ack_busy", {rd_ack, sched_busy}, 2'b11);
    rd_req = 1'b0;
    @(negedge clk_ref);
    check("t1_first_start", {sd_rd_start_en, sd_rd_sec_addr}, {1'b1, 32'h100});
    wait_done(1'b0, "t1_done");
    check("t1_sec_cnt", sec_cnt, 16'd3);
    check("t1_err", timeout_err, 1'b0);
    repeat (3) @(negedge clk_ref);
    check("t1_done_cnt", rd_done_cnt - d0, 1);
    check("t1_idle", sched_busy, 1'b0);

    // write 2 sectors across the 32-bit address wrap
    exp_q.push_back({1'b1, 32'hFFFF_FFFF});
    exp_q.push_back({1'b1, 32'h0000_0000});
    start_job(1'b1, 32'hFFFF_FFFF, 16'd2);
    wait_ack(1'b1, "wrap_ack");
    wait_done(1'b1, "wrap_done");
    check("wrap_sec_cnt", sec_cnt, 16'd2);
    check("wrap_addrs", {sd_wr_sec_addr, sd_rd_sec_addr}, {32'h0, 32'h102});
    repeat (2) @(negedge clk_ref);

    // zero-length write: ack, then done next cycle, no start pulse
    start_job(1'b1, 32'h500, 16'd0);
    @(negedge clk_ref);
    check("z_ack", {wr_ack, wr_done}, 2'b10);
    wr_req = 1'b0;
    @(negedge clk_ref);
    check("z_done", {wr_done, wr_ack, sched_busy}, 3'b100);
    @(negedge clk_ref);
    check("z_after", {wr_done, sec_cnt}, 17'h0);
    check("z_addr_hold", sd_wr_sec_addr, 32'h0);

    // busy never rises: timeout 11 cycles after the start pulse
    model_en = 1'b0;
    exp_q.push_back({1'b1, 32'h700});
    start_job(1'b1, 32'h700, 16'd1);
    wait_ack(1'b1, "tmo_ack");
    @(negedge clk_ref);
    check("tmo_start", sd_wr_start_en, 1'b1);
    repeat (10) @(negedge clk_ref);
    check("tmo_err_early", timeout_err, 1'b0);
    @(negedge clk_ref);
    check("tmo_err_rise", {timeout_err, wr_done, sched_busy}, 3'b101);
    @(negedge clk_ref);
    check("tmo_done", {wr_done, timeout_err, sec_cnt}, {1'b1, 1'b1, 16'h0});
    model_en = 1'b1;
    start_job(1'b0, 32'h800, 16'd0);
    @(negedge clk_ref);
    check("tmo_clear", {rd_ack, timeout_err}, 2'b10);
    rd_req = 1'b0;
    repeat (3) @(negedge clk_ref);

    // sd_init_done drop in WAIT_LO aborts; no accept while it is low
    exp_q.push_back({1'b0, 32'h900});
    start_job(1'b0, 32'h900, 16'd2);
    wait_ack(1'b0, "ab_ack");
    wait_busy(1'b0, "ab_busy");
    repeat (3) @(negedge clk_ref);
    sd_init_done = 1'b0;
    @(negedge clk_ref);
    check("ab_err", {timeout_err, sched_busy, rd_done}, 3'b110);
    @(negedge clk_ref);
    check("ab_done", {rd_done, sched_busy, sec_cnt}, {1'b1, 1'b0, 16'h0});
    d0 = rd_ack_cnt;
    start_job(1'b0, 32'hA00, 16'd0);
    repeat (8) @(negedge clk_ref);
    check("ab_no_accept", {rd_ack_cnt - d0, 31'(sched_busy)}, 64'h0);
    sd_init_done = 1'b1;
    @(negedge clk_ref);
    check("ab_reaccept", {rd_ack, timeout_err}, 2'b10);
    rd_req = 1'b0;
    repeat (25) @(negedge clk_ref);

    // asynchronous reset in WAIT_LO of the second sector
    exp_q.push_back({1'b1, 32'hB00});
    exp_q.push_back({1'b1, 32'hB01});
    start_job(1'b1, 32'hB00, 16'd2);
    wait_ack(1'b1, "rst_job_ack");
    seen = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk_ref);
      if (sec_cnt == 16'd1) begin seen = 1'b1; break; end
    end
    check("rst_job_sec1", seen, 1'b1);
    wait_busy(1'b1, "rst_job_busy");
    repeat (3) @(negedge clk_ref);
    check("rst_pre", {sched_busy, sd_wr_sec_addr}, {1'b1, 32'hB01});
    #2 rst_n = 1'b0;
    #1;
    check("rst_async", {sched_busy, timeout_err, sec_cnt, sd_wr_sec_addr, sd_rd_sec_addr},
          {2'b00, 16'h0, 32'h0, 32'h0});
    @(negedge clk_ref);
    rst_n = 1'b1;
    d0 = wr_done_cnt;
    repeat (30) @(negedge clk_ref);
    check("rst_no_resume", {wr_done_cnt - d0, 31'(sched_busy)}, 64'h0);

    check("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
